// File: rtl/mult_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_scheduler_if
// Purpose  : Bundles the requester-side handshake and the multiplier-side
//            control signals of the round-robin multiplier scheduler.
// Ports    : req/a_in/b_in/ack           - requester handshake
//            rsp_valid/rsp_err/rsp_result - response bus
//            mul_start/mul_a/mul_b        - drive to shared multiplier
//            mul_result/mul_done          - return from shared multiplier
//            busy                         - scheduler not idle
// Modports : slave  - scheduler view
//            master - environment view (requesters + multiplier)
// Revision : 1.0 - initial release
// ============================================================================
interface mult_rr_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 4
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_in;
   logic [N_REQ*WIDTH-1:0] b_in;
   logic [N_REQ-1:0]       ack;
   logic [N_REQ-1:0]       rsp_valid;
   logic                   rsp_err;
   logic [2*WIDTH-1:0]     rsp_result;
   logic                   mul_start;
   logic [WIDTH-1:0]       mul_a;
   logic [WIDTH-1:0]       mul_b;
   logic [2*WIDTH-1:0]     mul_result;
   logic                   mul_done;
   logic                   busy;

   modport slave (
      input  req, a_in, b_in, mul_result, mul_done,
      output ack, rsp_valid, rsp_err, rsp_result, mul_start, mul_a, mul_b, busy
   );

   modport master (
      output req, a_in, b_in, mul_result, mul_done,
      input  ack, rsp_valid, rsp_err, rsp_result, mul_start, mul_a, mul_b, busy
   );
endinterface
`default_nettype wire

// File: rtl/mult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mult_rr_scheduler
// Purpose  : Shares one sequential multiplier among N_REQ requesters. Grants
//            one request per idle visit in round-robin order, issues the
//            operands with a start pulse, waits for a qualified done (or a
//            timeout) and returns the product to the owner as a one-cycle
//            response pulse.
// Ports    : clk  - clock, all logic on the rising edge
//            rst  - asynchronous active-high reset
//            bus  - mult_rr_scheduler_if.slave (requester handshake,
//                   response bus, multiplier control/return, busy)
// Revision : 1.0 - initial release
// ============================================================================
module mult_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 64
) (
   input wire logic              clk,
   input wire logic              rst,
   mult_rr_scheduler_if.slave    bus
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]         state_q,      state_d;
   logic [PTR_W-1:0]   ptr_q,        ptr_d;
   logic [PTR_W-1:0]   owner_q,      owner_d;
   logic               armed_q,      armed_d;
   logic [CNT_W-1:0]   cnt_q,        cnt_d;
   logic [N_REQ-1:0]   ack_q,        ack_d;
   logic [N_REQ-1:0]   rsp_valid_q,  rsp_valid_d;
   logic               rsp_err_q,    rsp_err_d;
   logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic               mul_start_q,  mul_start_d;
   logic [WIDTH-1:0]   mul_a_q,      mul_a_d;
   logic [WIDTH-1:0]   mul_b_q,      mul_b_d;
   logic               busy_q,       busy_d;

   logic               grant_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   cand;
   logic               done_qual;
   logic               timeout_hit;

   // A done level left over from the previous operation must not complete
   // this one, so done only counts once a low level has been seen in WAIT.
   assign done_qual   = bus.mul_done & armed_q;
   // The counter holds the number of WAIT cycles already spent; the cycle in
   // which it would reach TIMEOUT is the last one allowed.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   // ------------------------------------------------------------------------
   // Round-robin pick: first requester set at or above ptr, wrapping around.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % N_REQ);
         if (!grant_found && bus.req[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         owner_q      <= '0;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         ack_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_result_q <= '0;
         mul_start_q  <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         owner_q      <= owner_d;
         armed_q      <= armed_d;
         cnt_q        <= cnt_d;
         ack_q        <= ack_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         rsp_result_q <= rsp_result_d;
         mul_start_q  <= mul_start_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         busy_q       <= busy_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_found) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (done_qual || timeout_hit) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output and datapath logic (all results land in registers)
   // ------------------------------------------------------------------------
   always_comb begin
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      armed_d      = armed_q;
      cnt_d        = cnt_q;
      ack_d        = '0;
      mul_start_d  = 1'b0;
      rsp_valid_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_result_d = rsp_result_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      busy_d       = (state_d != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               owner_d            = grant_idx;
               ptr_d              = (grant_idx == PTR_W'(N_REQ - 1)) ? '0
                                                                     : grant_idx + PTR_W'(1);
               mul_a_d            = bus.a_in[int'(grant_idx)*WIDTH +: WIDTH];
               mul_b_d            = bus.b_in[int'(grant_idx)*WIDTH +: WIDTH];
               ack_d[grant_idx]   = 1'b1;
               mul_start_d        = 1'b1;
            end
         end
         S_ISSUE: begin
            armed_d = 1'b0;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!bus.mul_done) armed_d = 1'b1;
            // Done takes priority over a timeout in the same cycle.
            if (done_qual) begin
               rsp_result_d         = bus.mul_result;
               rsp_valid_d[owner_q] = 1'b1;
            end else if (timeout_hit) begin
               rsp_result_d         = '0;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_err_d            = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.ack        = ack_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.mul_start  = mul_start_q;
   assign bus.mul_a      = mul_a_q;
   assign bus.mul_b      = mul_b_q;
   assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_rr_scheduler
// Purpose  : Self-checking bench for mult_rr_scheduler with a configurable
//            behavioural multiplier (latency, stale done window, hang) and a
//            transaction-level reference model of grant order and response
//            timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_rr_scheduler;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mult_rr_scheduler_if #(.N_REQ(N), .WIDTH(W)) bus ();

   mult_rr_scheduler #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // ------------------------------------------------------------------------
   // Behavioural multiplier. Cycle k after the start edge: done is forced
   // high for k <= stale_cfg (leftover level), then rises for good at
   // k == lat_cfg unless hang_cfg is set.
   // ------------------------------------------------------------------------
   int   lat_cfg   = 4;
   int   stale_cfg = 0;
   bit   hang_cfg  = 1'b0;
   logic md;
   logic [2*W-1:0] mr;
   logic [W-1:0]   ma, mb;
   int   mk;

   function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
   endfunction

   function automatic bit real_done(input int k);
      return !hang_cfg && (k > stale_cfg) && (k >= lat_cfg);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         md <= 1'b0; mr <= '0; mk <= 0; ma <= '0; mb <= '0;
      end else if (bus.mul_start) begin
         mk <= 1;
         ma <= bus.mul_a;
         mb <= bus.mul_b;
         md <= (stale_cfg >= 1) || real_done(1);
         if (real_done(1)) mr <= prod(bus.mul_a, bus.mul_b);
      end else if (mk > 0 && mk < 100000) begin
         mk <= mk + 1;
         md <= (mk + 1 <= stale_cfg) || real_done(mk + 1);
         if (real_done(mk + 1)) mr <= prod(ma, mb);
      end
   end

   assign bus.mul_done   = md;
   assign bus.mul_result = mr;

   // ------------------------------------------------------------------------
   // Reference model: cycle index, idle flag, rr pointer, pending response.
   // ------------------------------------------------------------------------
   int             n = 0;
   bit             m_idle = 1'b1;
   int             m_ptr = 0;
   int             m_owner = 0;
   int             m_rsp_at = -10;
   logic [W-1:0]   m_a = '0, m_b = '0;
   logic [2*W-1:0] m_res = '0;
   bit             m_err = 1'b0;
   logic [N-1:0]   rearm = '0;
   logic [N-1:0]   e_ack, e_rsp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, n);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_ack"},        32'(bus.ack),        0);
      chk({tag, "_rsp_valid"},  32'(bus.rsp_valid),  0);
      chk({tag, "_rsp_err"},    32'(bus.rsp_err),    0);
      chk({tag, "_rsp_result"}, 32'(bus.rsp_result), 0);
      chk({tag, "_mul_start"},  32'(bus.mul_start),  0);
      chk({tag, "_mul_a"},      32'(bus.mul_a),      0);
      chk({tag, "_mul_b"},      32'(bus.mul_b),      0);
      chk({tag, "_busy"},       32'(bus.busy),       0);
   endtask

   // One clock: capture this cycle's inputs, advance, predict, compare, then
   // let requesters drop req on ack (and re-raise on response if rearmed).
   task automatic step();
      logic [N-1:0]   s_req;
      logic [N*W-1:0] s_a, s_b;
      bit             p_idle;
      int             g;
      s_req  = bus.req;
      s_a    = bus.a_in;
      s_b    = bus.b_in;
      p_idle = m_idle;
      @(posedge clk);
      #1;
      n++;
      e_ack = '0;
      e_rsp = '0;
      if (!m_idle && n == m_rsp_at + 1) m_idle = 1'b1;
      if (p_idle && s_req != '0) begin
         g        = rr_pick(s_req, m_ptr);
         e_ack[g] = 1'b1;
         m_ptr    = (g + 1) % N;
         m_owner  = g;
         m_idle   = 1'b0;
         m_a      = s_a[g*W +: W];
         m_b      = s_b[g*W +: W];
         if (!hang_cfg && lat_cfg <= TO) begin
            m_rsp_at = n + lat_cfg + 1; m_res = prod(m_a, m_b); m_err = 1'b0;
         end else begin
            m_rsp_at = n + TO + 1;      m_res = '0;             m_err = 1'b1;
         end
      end
      if (!m_idle && n == m_rsp_at) e_rsp[m_owner] = 1'b1;
      chk("ack",       32'(bus.ack),       32'(e_ack));
      chk("mul_start", 32'(bus.mul_start), 32'(|e_ack));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
      chk("busy",      32'(bus.busy),      32'(!m_idle));
      chk("mul_a",     32'(bus.mul_a),     32'(m_a));
      chk("mul_b",     32'(bus.mul_b),     32'(m_b));
      if (e_rsp != '0) begin
         chk("rsp_result", 32'(bus.rsp_result), 32'(m_res));
         chk("rsp_err",    32'(bus.rsp_err),    32'(m_err));
      end else begin
         chk("rsp_err_idle", 32'(bus.rsp_err), 0);
      end
      bus.req = (bus.req & ~e_ack) | (e_rsp & rearm);
   endtask

   task automatic drain(input int maxc);
      int c;
      c = 0;
      while (!(bus.req == '0 && m_idle) && c < maxc) begin
         step();
         c++;
      end
      if (c >= maxc) chk("drain_timeout", 0, 1);
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      bus.a_in[i*W +: W] = W'(a);
      bus.b_in[i*W +: W] = W'(b);
   endtask

   // ------------------------------------------------------------------------
   // Single-request vector table
   // ------------------------------------------------------------------------
   typedef struct packed {
      int idx;
      int a;
      int b;
      int lat;
      int stale;
      bit hang;
      int exp_res;
      bit exp_err;
      int exp_lat;   // cycles from ack to rsp_valid
   } vec_t;

   vec_t tbl [7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   got, ack_c, rsp_c, na, nr, cnt, last, g, first;
      int   order [N];
      int   res   [N];
      logic [N-1:0]   rbit;
      logic [2*W-1:0] rres;
      logic           rerr;

      tbl[0] = '{1,  3,  2,  4, 0, 1'b0,   6, 1'b0,  5};
      tbl[1] = '{2, 15, 15,  8, 2, 1'b0, 225, 1'b0,  9};  // stale done window
      tbl[2] = '{0,  0,  9,  2, 0, 1'b0,   0, 1'b0,  3};  // minimum latency
      tbl[3] = '{3, 15,  1, 16, 0, 1'b0,  15, 1'b0, 17};  // done on timeout cycle wins
      tbl[4] = '{1,  7,  7, 17, 0, 1'b0,   0, 1'b1, 17};  // one cycle too late
      tbl[5] = '{2,  5,  5,  6, 0, 1'b1,   0, 1'b1, 17};  // hung multiplier
      tbl[6] = '{3,  9,  9,  3, 1, 1'b0,  81, 1'b0,  4};  // normal after timeout

      rst = 1'b0;
      bus.req  = '0;
      bus.a_in = '0;
      bus.b_in = '0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      // ---- four simultaneous requests, ptr = 0 after reset ----
      set_ops(0, 5, 5); set_ops(1, 15, 0); set_ops(2, 15, 15); set_ops(3, 1, 7);
      lat_cfg = 5; stale_cfg = 0; hang_cfg = 1'b0;
      bus.req = '1;
      na = 0; nr = 0;
      for (int i = 0; i < N; i++) begin order[i] = -1; res[i] = -1; end
      for (int c = 0; c < 80 && nr < 4; c++) begin
         step();
         if (bus.ack != '0 && na < N) begin order[na] = oh_idx(bus.ack); na++; end
         if (bus.rsp_valid != '0) begin
            g = oh_idx(bus.rsp_valid);
            res[g] = int'(bus.rsp_result);
            nr++;
         end
      end
      for (int i = 0; i < N; i++) chk("four_order", 32'(order[i]), 32'(i));
      chk("four_res0", 32'(res[0]), 25);
      chk("four_res1", 32'(res[1]), 0);
      chk("four_res2", 32'(res[2]), 225);
      chk("four_res3", 32'(res[3]), 7);
      drain(40);

      // ---- table-driven single requests ----
      for (int t = 0; t < 7; t++) begin
         lat_cfg = tbl[t].lat; stale_cfg = tbl[t].stale; hang_cfg = tbl[t].hang;
         set_ops(tbl[t].idx, tbl[t].a, tbl[t].b);
         bus.req[tbl[t].idx] = 1'b1;
         got = 0; ack_c = -100; rsp_c = 0; rbit = '0; rres = '0; rerr = 1'b0;
         for (int c = 0; c < 40 && got == 0; c++) begin
            step();
            if (bus.ack != '0) ack_c = n;
            if (bus.rsp_valid != '0) begin
               got = 1; rsp_c = n;
               rbit = bus.rsp_valid; rres = bus.rsp_result; rerr = bus.rsp_err;
            end
         end
         if (got == 0) begin
            chk("tbl_no_response", 0, 1);
         end else begin
            chk("tbl_rsp_bit", 32'(rbit), 32'(1) << tbl[t].idx);
            chk("tbl_result",  32'(rres), 32'(tbl[t].exp_res));
            chk("tbl_err",     32'(rerr), 32'(tbl[t].exp_err));
            chk("tbl_latency", 32'(rsp_c - ack_c), 32'(tbl[t].exp_lat));
         end
         drain(40);
      end

      // ---- fairness: requesters 0 and 2 re-raise on every response ----
      lat_cfg = 3; stale_cfg = 0; hang_cfg = 1'b0;
      set_ops(0, 2, 3); set_ops(2, 4, 5);
      rearm = 4'b0101;
      bus.req[0] = 1'b1;
      bus.req[2] = 1'b1;
      cnt = 0; last = -1;
      for (int c = 0; c < 100 && cnt < 6; c++) begin
         step();
         if (bus.ack != '0) begin
            g = oh_idx(bus.ack);
            chk("fair_member", 32'(g == 0 || g == 2), 1);
            if (cnt > 0) chk("fair_alternate", 32'(g), (last == 0) ? 32'd2 : 32'd0);
            last = g;
            cnt++;
         end
      end
      chk("fair_grant_count", 32'(cnt), 6);
      rearm = '0;
      drain(60);

      // ---- randomized traffic against the model ----
      for (int c = 0; c < 400; c++) begin
         if (m_idle) begin
            hang_cfg  = ($urandom_range(0, 9) == 0);
            lat_cfg   = int'($urandom_range(2, 18));
            stale_cfg = int'($urandom_range(0, (lat_cfg - 2 < 3) ? lat_cfg - 2 : 3));
         end
         for (int i = 0; i < N; i++) begin
            if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
               set_ops(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
               bus.req[i] = 1'b1;
            end
         end
         step();
      end
      drain(200);

      // ---- reset in the middle of WAIT ----
      lat_cfg = 10; stale_cfg = 0; hang_cfg = 1'b0;
      set_ops(1, 6, 6);
      bus.req[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
         step();
         if (bus.ack != '0) got = 1;
      end
      chk("midrst_granted", 32'(got), 1);
      repeat (3) step();
      #3 rst = 1'b1;
      #1;
      check_all_zero("midrst");
      bus.req = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      n++;
      m_idle = 1'b1; m_ptr = 0; m_a = '0; m_b = '0; m_rsp_at = -10;
      lat_cfg = 3;
      set_ops(3, 2, 2); set_ops(0, 3, 3);
      bus.req = 4'b1001;
      first = -1; nr = 0;
      for (int c = 0; c < 40 && nr < 2; c++) begin
         step();
         if (bus.ack != '0 && first < 0) first = oh_idx(bus.ack);
         if (bus.rsp_valid != '0) nr++;
      end
      chk("midrst_first_grant", 32'(first), 0);
      chk("midrst_responses",   32'(nr),    2);
      drain(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
